positadd_prod_4_raw: RTL and testbench

- Fully pipelined, 4-stage adder for es=2 posit arithmetic. Adds two raw (unrounded) product-format values, such as multiplier outputs, and produces a raw sum-format value.
- The output is not rounded or packed to posit form; a downstream normalizer/rounder does that.
- Accepts one operation per cycle; a truncated flag reports bits lost during alignment or normalization.

---
 rtl/positadd_prod_4_raw.sv | 110 +++++++++++
 tb/tb_positadd_prod_4_raw.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/positadd_prod_4_raw.sv
// positadd_prod_4_raw: 4-stage es=2 posit raw adder; in1/in2 product format + start in, result sum format + done/truncated out
module positadd_prod_4_raw #(
    parameter  int FRAC_W  = 56,
    parameter  int SCALE_W = 9,
    localparam int PW      = 1 + SCALE_W + FRAC_W + 2,
    localparam int SW      = PW + 2,
    localparam int MW      = FRAC_W + 3,
    localparam int LW      = $clog2(MW)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [PW-1:0] in1,
    input  logic [PW-1:0] in2,
    input  logic          start,
    output logic [SW-1:0] result,
    output logic          done,
    output logic          truncated
);
    typedef struct packed {
        logic v, inf, zero, sign, sub, bz;
        logic [SCALE_W:0] scale, diff;
        logic [FRAC_W-1:0] fa, fb;
    } s1_t;
    typedef struct packed {
        logic v, inf, zero, sign, sub, sticky;
        logic [SCALE_W:0] scale;
        logic [MW-1:0] ma, mb;
    } s2_t;
    typedef struct packed {
        logic v, inf, zero, sign, sticky;
        logic [SCALE_W:0] scale;
        logic [MW-1:0] m;
    } s3_t;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic [SW-1:0] result_d, result_q;
    logic done_d, done_q, truncated_d, truncated_q;
    logic signed [SCALE_W-1:0] sc1, sc2;
    logic a_is_1;
    logic [PW-1:0] op_a, op_b;
    logic [MW-1:0] mb_full;
    logic [LW-1:0] lzc;
    logic [MW-3:0] norm, frac_n;
    logic [SCALE_W:0] scale_n;
    always_comb begin
        sc1 = in1[PW-2 -: SCALE_W];
        sc2 = in2[PW-2 -: SCALE_W];
        // a zero operand always loses; among nonzero ones ties keep in1 as A
        a_is_1 = in2[0] | (!in1[0] & ((sc1 > sc2) | ((sc1 == sc2) & (in1[FRAC_W+1:2] >= in2[FRAC_W+1:2]))));
        op_a = a_is_1 ? in1 : in2;
        op_b = a_is_1 ? in2 : in1;
        s1_d.v = start;
        s1_d.inf = in1[1] | in2[1];
        s1_d.zero = in1[0] & in2[0];
        s1_d.sign = op_a[PW-1];
        s1_d.sub = op_a[PW-1] ^ op_b[PW-1];
        s1_d.bz = in1[0] | in2[0];
        s1_d.scale = {op_a[PW-2], op_a[PW-2 -: SCALE_W]};
        s1_d.diff = s1_d.scale - {op_b[PW-2], op_b[PW-2 -: SCALE_W]};
        s1_d.fa = op_a[FRAC_W+1:2];
        s1_d.fb = op_b[FRAC_W+1:2];
        mb_full = s1_q.bz ? '0 : {2'b01, s1_q.fb, 1'b0};
        s2_d.v = s1_q.v;
        s2_d.inf = s1_q.inf;
        s2_d.zero = s1_q.zero;
        s2_d.sign = s1_q.sign;
        s2_d.sub = s1_q.sub;
        s2_d.scale = s1_q.scale;
        s2_d.ma = {2'b01, s1_q.fa, 1'b0};
        // shifts of MW or more clear the operand and make the mask all ones
        s2_d.mb = mb_full >> s1_q.diff;
        s2_d.sticky = |(mb_full & ~({MW{1'b1}} << s1_q.diff));
        s3_d.v = s2_q.v;
        s3_d.inf = s2_q.inf;
        s3_d.zero = s2_q.zero;
        s3_d.sign = s2_q.sign;
        s3_d.sticky = s2_q.sticky;
        s3_d.scale = s2_q.scale;
        s3_d.m = s2_q.sub ? s2_q.ma - s2_q.mb : s2_q.ma + s2_q.mb;
        lzc = '0;
        for (int i = 0; i < MW - 1; i++) if (s3_q.m[i]) lzc = LW'(MW - 2 - i);
        norm = s3_q.m[MW-3:0] << lzc;
        frac_n = s3_q.m[MW-1] ? s3_q.m[MW-2:1] : norm;
        scale_n = s3_q.m[MW-1] ? s3_q.scale + 1'b1 : s3_q.scale - (SCALE_W+1)'(lzc);
        done_d = s3_q.v;
        result_d = !s3_q.v ? result_q : s3_q.inf ? SW'(2) : (s3_q.zero | ~|s3_q.m) ? SW'(1) : {s3_q.sign, scale_n, frac_n, 2'b00};
        truncated_d = !s3_q.v ? truncated_q : !(s3_q.inf | s3_q.zero) & (s3_q.sticky | (s3_q.m[MW-1] & s3_q.m[0]));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            done_q <= 1'b0;
            result_q <= '0;
            truncated_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            done_q <= done_d;
            result_q <= result_d;
            truncated_q <= truncated_d;
        end
    end
    assign result = result_q;
    assign done = done_q;
    assign truncated = truncated_q;
endmodule

// File: tb/tb_positadd_prod_4_raw.sv
// tb_positadd_prod_4_raw: randomized self-checking bench with an exact-arithmetic reference model
module tb_positadd_prod_4_raw;
    logic clk = 0, reset_n = 0, start = 0;
    logic [67:0] in1 = '0, in2 = '0;
    logic [69:0] result;
    logic done, truncated;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    positadd_prod_4_raw dut (
        .clk(clk), .reset_n(reset_n), .in1(in1), .in2(in2), .start(start),
        .result(result), .done(done), .truncated(truncated)
    );
    // returns {truncated, result}; the value is carried as an integer mantissa with explicit scale
    function automatic logic [70:0] model(input logic [67:0] x, input logic [67:0] y);
        logic [67:0] a, b;
        logic [63:0] ma, mb, m;
        int sa, sb, d, sc;
        logic lost;
        if (x[1] | y[1]) return 71'h2;
        if (x[0] & y[0]) return 71'h1;
        sa = int'($signed(x[66:58]));
        sb = int'($signed(y[66:58]));
        if (y[0] || (!x[0] && (sa > sb || (sa == sb && x[57:2] >= y[57:2])))) begin
            a = x;
            b = y;
        end else begin
            a = y;
            b = x;
        end
        sa = int'($signed(a[66:58]));
        sb = int'($signed(b[66:58]));
        ma = (64'd1 << 57) | (64'(a[57:2]) << 1);
        mb = b[0] ? 64'd0 : (64'd1 << 57) | (64'(b[57:2]) << 1);
        d = sa - sb;
        if (d >= 59) begin
            lost = mb != 0;
            mb = 0;
        end else begin
            lost = ((mb >> d) << d) != mb;
            mb = mb >> d;
        end
        m = (a[67] == b[67]) ? ma + mb : ma - mb;
        if (m == 0) return {lost, 70'h1};
        sc = sa;
        if (m >= (64'd1 << 58)) begin
            lost = lost | m[0];
            m = m >> 1;
            sc++;
        end else begin
            while (m < (64'd1 << 57)) begin
                m = m << 1;
                sc--;
            end
        end
        return {lost, a[67], 10'(sc), 57'(m - (64'd1 << 57)), 2'b00};
    endfunction
    task automatic chk(input string n, input logic [70:0] a, input logic [70:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    logic [2:0] pv;
    logic [70:0] pm [3];
    logic exp_done, exp_tr;
    logic [69:0] exp_res;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            exp_done <= 0;
            exp_res <= '0;
            exp_tr <= 0;
        end else begin
            pv <= {pv[1:0], start};
            pm[0] <= model(in1, in2);
            pm[1] <= pm[0];
            pm[2] <= pm[1];
            exp_done <= pv[2];
            if (pv[2]) {exp_tr, exp_res} <= pm[2];
        end
    end
    always @(negedge clk) begin
        chk("done", 71'(done), 71'(exp_done));
        chk("result", 71'(result), 71'(exp_res));
        chk("truncated", 71'(truncated), 71'(exp_tr));
    end
    task automatic run_op(input string n, input logic [67:0] a, input logic [67:0] b, input logic [69:0] er, input logic et);
        int cnt;
        @(negedge clk);
        in1 = a;
        in2 = b;
        start = 1;
        cnt = 0;
        do begin
            @(negedge clk);
            start = 0;
            cnt++;
        end while (!done && cnt < 10);
        chk({n, "_latency"}, 71'(cnt), 71'(4));
        chk({n, "_result"}, 71'(result), 71'(er));
        chk({n, "_trunc"}, 71'(truncated), 71'(et));
    endtask
    function automatic logic [67:0] rnd_op();
        logic [67:0] v;
        int k;
        k = $urandom_range(0, 15);
        v = 68'({$urandom, $urandom, $urandom});
        if (k < 10) v[66:58] = 9'($urandom_range(0, 16)) - 9'd8;
        v[1:0] = k == 10 ? 2'b01 : k == 11 ? 2'b10 : 2'b00;
        return v;
    endfunction
    logic [67:0] tiny, neg1;
    logic [69:0] two;
    initial begin
        tiny = '0;
        tiny[66:58] = 9'h19C;
        neg1 = '0;
        neg1[67] = 1'b1;
        two = '0;
        two[59] = 1'b1;
        chk("model_pass_zero", model(68'h0, 68'h1), 71'h0);
        chk("model_double", model(68'h0, 68'h0), {1'b0, two});
        chk("model_cancel", model(68'h0, neg1), 71'h1);
        chk("model_tiny", model(68'h0, tiny), {1'b1, 70'h0});
        chk("model_inf", model(68'h5a, 68'h2), 71'h2);
        repeat (3) @(negedge clk);
        reset_n = 1;
        run_op("pass_zero", 68'h0, 68'h1, 70'h0, 0);
        run_op("double", 68'h0, 68'h0, two, 0);
        run_op("cancel", 68'h0, neg1, 70'h1, 0);
        run_op("tiny", 68'h0, tiny, 70'h0, 1);
        run_op("inf", 68'h123456789, 68'h2, 70'h2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in1 = rnd_op();
            in2 = rnd_op();
            start = 1;
        end
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("rst_done", 71'(done), 71'(0));
        chk("rst_result", 71'(result), 71'(0));
        chk("rst_trunc", 71'(truncated), 71'(0));
        @(negedge clk);
        start = 0;
        reset_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_done", 71'(done), 71'(0));
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in1 = rnd_op();
            case ($urandom_range(0, 7))
                0: in2 = {~in1[67], in1[66:0]};
                1: in2 = {$urandom_range(0, 1) == 1, in1[66:58], 56'({$urandom, $urandom}), 2'b00};
                default: in2 = rnd_op();
            endcase
            start = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
